sd_block_reader_dat0: RTL and testbench
=======================================

// Module: sd_block_reader_dat0
// PURPOSE
//  Receive side of the single-block DAT0 data path; counterpart to the block writer.
//  After the command engine issues CMD17, this block samples DAT0 on SD clock rising edges.
//  It detects the start bit, assembles a BLOCK_BYTES-byte payload MSB-first and emits it as a byte stream.
//  It checks the trailing CRC16 and end bit, then reports done/crc_ok/timeout to the FAT32 read controller.
// PARAMETERS
//  BLOCK_BYTES     512      payload bytes per block (address width = clog2(BLOCK_BYTES))
//  TIMEOUT_EDGES   1000000  sdclk rising edges to wait for the start bit before timeout
// PORTS
//  clk        in   1   system clock; sdclk is sampled in this domain
//  rstn       in   1   asynchronous active-low reset; 1 = working, 0 = reset
//  sdclk      in   1   SD clock produced by the command engine (slower than clk, >= 4 clk per period)
//  sddat0     in   1   DAT0 line; this block never drives it
//  arm        in   1   1-cycle pulse: expect a data block (issued together with CMD17)
//  busy       out  1   1 from accepted arm until done
//  outen      out  1   1-cycle strobe: outbyte/outaddr valid
//  outaddr    out  9   byte index within block, 0..BLOCK_BYTES-1
//  outbyte    out  8   received byte, first bit on the wire = bit 7
//  done       out  1   1-cycle pulse at end of block or on timeout
//  crc_ok     out  1   valid from done until next arm: received CRC == computed CRC and end bit == 1
//  timeout    out  1   valid from done until next arm: no start bit within TIMEOUT_EDGES
// BEHAVIOUR
//  - Reset: all outputs 0. State = IDLE. Counters, shift register and CRC = 0. Reset mid-block aborts silently (no done).
//  - Edge detect: register sdclkl <= sdclk. Sample event = ~sdclkl & sdclk.
//    - All DAT0 sampling and state advance occur only on sample events.
//    - Sampled bit is the value of sddat0 in that clk cycle.
//  - States:
//    IDLE       arm -> WAIT_START; clear crc_ok, timeout, edge counter and CRC; busy <= 1.
//    WAIT_START on each sample: sddat0 == 0 -> DATA, bit counter = 0.
//               Otherwise increment edge counter; when counter reaches TIMEOUT_EDGES -> FINISH with timeout = 1.
//    DATA       shift bit into byte register; CRC <= crc16_step(CRC, bit).
//               On the 8th bit of a byte: outbyte <= assembled byte, outaddr <= byte index, outen = 1 for exactly one clk.
//               After bit BLOCK_BYTES*8-1 -> RX_CRC.
//    RX_CRC     shift 16 bits MSB-first into rx_crc; the CRC engine is not updated; after 16th bit -> END_BIT.
//    END_BIT    next sample is the end bit -> FINISH.
//               crc_ok <= (rx_crc == CRC) && (bit == 1).
//    FINISH     done = 1 for one clk; busy <= 0; -> IDLE. crc_ok and timeout hold until the next arm.
//  - CRC16: polynomial x^16+x^12+x^5+1, initial value 0x0000, MSB-first, no final XOR. Shares the serial step with the writer's CRC.
//  - Latency: outen asserts in the clk cycle after the sample event that captured bit 0 of the byte (the last bit on the wire).
//    done asserts 1 clk after the end-bit sample.
//  - arm while busy is ignored. arm in the same cycle as done is also ignored; the read controller re-arms afterwards.
//  - Start-bit search ignores sddat0 == 1 idle bits and tolerates any number of them up to the timeout.
//  - Edge counter is 32 bit and saturates at TIMEOUT_EDGES; there is no wrap.
//  - outaddr wraps only via return to IDLE. Exactly BLOCK_BYTES outen strobes are issued per successful block; none on timeout.
// TESTING
//  1. Arm, 10 idle 1s, start bit, 512 x 0xFF, CRC 0x7FA1, end bit 1 -> 512 outen with outbyte=0xFF, outaddr 0..511.
//     Then done=1, crc_ok=1, timeout=0.
//  2. Same block but payload bytes = index[7:0] (0x00..0xFF twice) with CRC computed by bench model.
//     -> bytes match, crc_ok=1. Flip one payload bit -> crc_ok=0, still 512 outen.
//  3. Arm with DAT0 held 1, TIMEOUT_EDGES=100 -> done on the sample after edge 100; timeout=1, crc_ok=0, no outen.
//  4. Valid block but end bit 0 -> done=1, crc_ok=0.
//  5. Assert rstn=0 after byte 200 -> all outputs 0 immediately. Re-arm after release -> a clean block is received correctly.
//  6. Pulse arm again during DATA -> ignored. sdclk:clk ratios 1:4 and 1:96 both pass scenario 1.

Source files
------------

// File: rtl/sd_block_reader_dat0.sv
// Single-block DAT0 receiver: finds the start bit, streams the payload out byte by byte,
// then checks the trailing CRC16 and end bit. Reports done/crc_ok/timeout.
module sd_block_reader_dat0 #(
    parameter int unsigned BLOCK_BYTES   = 512,
    parameter int unsigned TIMEOUT_EDGES = 1000000
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sdclk,
    input  logic                           sddat0,
    input  logic                           arm,
    output logic                           busy,
    output logic                           outen,
    output logic [$clog2(BLOCK_BYTES)-1:0] outaddr,
    output logic [7:0]                     outbyte,
    output logic                           done,
    output logic                           crc_ok,
    output logic                           timeout
);

    localparam int unsigned ADDR_W = $clog2(BLOCK_BYTES);
    localparam int unsigned BITS_W = $clog2(BLOCK_BYTES * 8);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_START = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] RX_CRC     = 3'd3;
    localparam logic [2:0] END_BIT    = 3'd4;
    localparam logic [2:0] FINISH     = 3'd5;

    logic [2:0]        state, state_nxt;
    logic              sdclkl;
    logic [31:0]       edge_cnt, edge_cnt_nxt;
    logic [BITS_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [15:0]       crc, crc_nxt;
    logic [15:0]       rx_crc, rx_crc_nxt;
    logic              busy_nxt, outen_nxt, done_nxt, crc_ok_nxt, timeout_nxt;
    logic [ADDR_W-1:0] outaddr_nxt;
    logic [7:0]        outbyte_nxt;
    logic              sample;
    logic [31:0]       edge_inc;
    logic [15:0]       crc_step;
    logic [7:0]        byte_asm;

    assign sample   = ~sdclkl & sdclk;
    assign edge_inc = edge_cnt + 32'd1;
    assign byte_asm = {shreg[6:0], sddat0};
    // Serial CRC16 (x^16+x^12+x^5+1) step for the bit currently on DAT0
    assign crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ sddat0) ? 16'h1021 : 16'h0000);

    // Next-state and registered-output logic
    always_comb begin
        state_nxt    = state;
        edge_cnt_nxt = edge_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        crc_nxt      = crc;
        rx_crc_nxt   = rx_crc;
        busy_nxt     = busy;
        outen_nxt    = 1'b0;
        done_nxt     = 1'b0;
        crc_ok_nxt   = crc_ok;
        timeout_nxt  = timeout;
        outaddr_nxt  = outaddr;
        outbyte_nxt  = outbyte;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt    = WAIT_START;
                    crc_ok_nxt   = 1'b0;
                    timeout_nxt  = 1'b0;
                    edge_cnt_nxt = 32'd0;
                    crc_nxt      = 16'h0000;
                    busy_nxt     = 1'b1;
                end
            end
            WAIT_START: begin
                if (sample) begin
                    if (!sddat0) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else if (edge_inc >= 32'(TIMEOUT_EDGES)) begin
                        edge_cnt_nxt = 32'(TIMEOUT_EDGES);
                        state_nxt    = FINISH;
                        timeout_nxt  = 1'b1;
                        done_nxt     = 1'b1;
                        busy_nxt     = 1'b0;
                    end else begin
                        edge_cnt_nxt = edge_inc;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_nxt = byte_asm;
                    crc_nxt   = crc_step;
                    if (bit_cnt[2:0] == 3'd7) begin
                        outen_nxt   = 1'b1;
                        outbyte_nxt = byte_asm;
                        outaddr_nxt = bit_cnt[BITS_W-1:3];
                    end
                    if (bit_cnt == BITS_W'(BLOCK_BYTES * 8 - 1)) begin
                        state_nxt   = RX_CRC;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BITS_W'(1);
                    end
                end
            end
            RX_CRC: begin
                if (sample) begin
                    rx_crc_nxt = {rx_crc[14:0], sddat0};
                    if (bit_cnt == BITS_W'(15)) begin
                        state_nxt = END_BIT;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BITS_W'(1);
                    end
                end
            end
            END_BIT: begin
                if (sample) begin
                    crc_ok_nxt = (rx_crc == crc) && sddat0;
                    state_nxt  = FINISH;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            sdclkl   <= 1'b0;
            edge_cnt <= 32'd0;
            bit_cnt  <= '0;
            shreg    <= 8'h00;
            crc      <= 16'h0000;
            rx_crc   <= 16'h0000;
            busy     <= 1'b0;
            outen    <= 1'b0;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            timeout  <= 1'b0;
            outaddr  <= '0;
            outbyte  <= 8'h00;
        end else begin
            state    <= state_nxt;
            sdclkl   <= sdclk;
            edge_cnt <= edge_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            crc      <= crc_nxt;
            rx_crc   <= rx_crc_nxt;
            busy     <= busy_nxt;
            outen    <= outen_nxt;
            done     <= done_nxt;
            crc_ok   <= crc_ok_nxt;
            timeout  <= timeout_nxt;
            outaddr  <= outaddr_nxt;
            outbyte  <= outbyte_nxt;
        end
    end

endmodule

// File: tb/tb_sd_block_reader_dat0.sv
// Bench for sd_block_reader_dat0: drives a DAT0 bit stream on a slow sdclk and checks every
// output each cycle against a sample-count model of where strobes and done must land.
module tb_sd_block_reader_dat0;

    localparam int BLOCK = 512;
    localparam int TO    = 100;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sdclk;
    logic       sddat0;
    logic       arm;
    logic       busy, outen, done, crc_ok, timeout;
    logic [8:0] outaddr;
    logic [7:0] outbyte;

    sd_block_reader_dat0 #(.BLOCK_BYTES(BLOCK), .TIMEOUT_EDGES(TO)) dut (
        .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat0(sddat0), .arm(arm),
        .busy(busy), .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
        .done(done), .crc_ok(crc_ok), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    logic [7:0] pay [BLOCK];

    function automatic logic [15:0] crc_pay();
        logic [15:0] c;
        c = 16'h0000;
        for (int k = 0; k < BLOCK; k++) c = crc_byte(c, pay[k]);
        return c;
    endfunction

    // SD line driver: new bit presented on each sdclk fall, idle 1 when nothing queued
    logic line_q[$];
    int   half = 2;
    event fall_ev;
    initial begin
        sdclk  = 1'b0;
        sddat0 = 1'b1;
        forever begin
            sdclk  = 1'b0;
            sddat0 = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
            -> fall_ev;
            repeat (half) @(negedge clk);
            sdclk = 1'b1;
            repeat (half) @(negedge clk);
        end
    end

    // Block-level model: everything is located by counting sample edges since the accepted arm
    int   exp_s0 = 0, exp_n_end = 0, ev_cnt = 0, exp_addr = 0;
    logic blk_crc_ok = 0, blk_tout = 0, arm_ok = 0;
    logic exp_busy = 0, exp_done = 0, exp_outen = 0, exp_crc_ok = 0, exp_tout = 0, prev_sd = 0;
    int   n_outen = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            exp_busy = 0; exp_done = 0; exp_outen = 0; exp_crc_ok = 0; exp_tout = 0;
            prev_sd = 0; ev_cnt = 0;
        end else begin
            logic ev;
            ev = sdclk && !prev_sd;
            prev_sd = sdclk;
            exp_done = 0;
            exp_outen = 0;
            if (arm && arm_ok && !exp_busy) begin
                exp_busy = 1; ev_cnt = 0; exp_crc_ok = 0; exp_tout = 0;
            end else if (exp_busy && ev) begin
                ev_cnt++;
                if (exp_s0 != 0 && ev_cnt > exp_s0 && ev_cnt <= exp_s0 + 8 * BLOCK
                    && (ev_cnt - exp_s0) % 8 == 0) begin
                    exp_outen = 1;
                    exp_addr  = (ev_cnt - exp_s0) / 8 - 1;
                end
                if (ev_cnt == exp_n_end) begin
                    exp_busy = 0; exp_done = 1; exp_crc_ok = blk_crc_ok; exp_tout = blk_tout;
                end
            end
        end
    end

    // Per-cycle compare
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_busy", busy, 0);
            chk("rst_outen", outen, 0);
            chk("rst_done", done, 0);
        end else begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("outen", outen, exp_outen);
            chk("crc_ok", crc_ok, exp_crc_ok);
            chk("timeout", timeout, exp_tout);
            if (outen && exp_outen) begin
                chk("outaddr", outaddr, exp_addr);
                chk("outbyte", outbyte, pay[exp_addr]);
            end
            if (outen) n_outen++;
        end
    end

    // mode: 0 plain, 1 extra arm during DATA, 2 arm in the done cycle, 3 reset after byte 200, 4 timeout
    task automatic run_block(input int idle, input logic endbit, input logic [15:0] crcv,
                             input logic ok, input int mode);
        int   budget;
        int   cyc;
        logic seen;
        if (mode == 4) begin
            exp_s0 = 0; exp_n_end = TO; blk_tout = 1; blk_crc_ok = 0;
        end else begin
            exp_s0 = idle + 2; exp_n_end = exp_s0 + 8 * BLOCK + 17; blk_tout = 0; blk_crc_ok = ok;
        end
        n_outen = 0;
        @(fall_ev);
        arm_ok = 1;
        arm = 1;
        if (mode != 4) begin
            for (int i = 0; i < idle; i++) line_q.push_back(1'b1);
            line_q.push_back(1'b0);
            for (int k = 0; k < BLOCK; k++)
                for (int b = 7; b >= 0; b--) line_q.push_back(pay[k][b]);
            for (int b = 15; b >= 0; b--) line_q.push_back(crcv[b]);
            line_q.push_back(endbit);
        end
        @(negedge clk);
        arm = 0;
        arm_ok = 0;
        budget = (exp_n_end + 4) * 2 * half + 20;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
            arm = (mode == 1 && cyc == 3000);
            if (done) seen = 1;
            if (mode == 3 && n_outen == 201) begin
                @(posedge clk);
                #1 rstn = 0;
                line_q.delete();
                #1;
                chk("async_rst_busy", busy, 0);
                chk("async_rst_outen", outen, 0);
                chk("async_rst_outaddr", outaddr, 0);
                chk("async_rst_outbyte", outbyte, 0);
                chk("async_rst_crc_ok", crc_ok, 0);
                chk("async_rst_timeout", timeout, 0);
                repeat (3) @(posedge clk);
                #1 rstn = 1;
                repeat (40) @(negedge clk);
                return;
            end
        end
        arm = 0;
        chk("done_seen", seen, 1);
        if (!seen) begin
            $display("FAIL wait_done: no done within %0d cycles", budget);
            n_fail++;
            return;
        end
        if (mode == 2) begin
            arm = 1;
            @(negedge clk);
            #1 arm = 0;
        end
        repeat (4) @(negedge clk);
        #1;
        chk("outen_count", n_outen, (mode == 4) ? 0 : BLOCK);
    endtask

    initial begin
        logic [15:0] c;
        string       s;
        int          pos;
        rstn = 1'b0;
        arm  = 1'b0;

        // Pin the CRC model with known values
        s = "123456789";
        c = 16'h0000;
        for (int i = 0; i < 9; i++) c = crc_byte(c, s[i]);
        chk("pin_crc_check_string", c, 16'h31C3);
        for (int k = 0; k < BLOCK; k++) pay[k] = 8'hFF;
        chk("pin_crc_ff_block", crc_pay(), 16'h7FA1);

        repeat (5) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (4) @(negedge clk);

        // All-0xFF block with its literal CRC; re-arm attempted in the done cycle
        run_block(10, 1'b1, 16'h7FA1, 1'b1, 2);

        // Index payload, random idle run, stray arm mid-block
        for (int k = 0; k < BLOCK; k++) pay[k] = k[7:0];
        c = crc_pay();
        run_block(int'($urandom_range(0, 60)), 1'b1, c, 1'b1, 1);

        // Same CRC, one payload bit flipped on the wire
        pos = int'($urandom_range(0, BLOCK * 8 - 1));
        pay[pos / 8] = pay[pos / 8] ^ (8'h80 >> (pos % 8));
        run_block(int'($urandom_range(0, 60)), 1'b1, c, 1'b0, 0);

        // Random payload, longest tolerated idle run, end bit 0
        for (int k = 0; k < BLOCK; k++) pay[k] = 8'($urandom);
        c = crc_pay();
        run_block(TO - 2, 1'b0, c, 1'b0, 0);

        // Timeout with DAT0 held high at a slow sdclk
        half = 48;
        run_block(0, 1'b1, 16'h0000, 1'b0, 4);
        half = 2;

        // Reset mid-block, then a clean block
        for (int k = 0; k < BLOCK; k++) pay[k] = 8'($urandom);
        c = crc_pay();
        run_block(int'($urandom_range(0, 60)), 1'b1, c, 1'b1, 3);
        for (int k = 0; k < BLOCK; k++) pay[k] = 8'($urandom);
        c = crc_pay();
        run_block(int'($urandom_range(0, 60)), 1'b1, c, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
